// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter feeding one UART TX.
// Optional build macro ARB_FIXED_PRIO_EN: fixed A-before-B tie-break in IDLE.
module uart_tx_arbiter #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 12000,
    parameter int CNT_W       = 14
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_a_valid,
    input  logic              i_a_last,
    output logic              o_a_ready,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_b_valid,
    input  logic              i_b_last,
    output logic              o_b_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic             last_b_q, last_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic             g_valid;
    logic             g_last;

    assign g_valid   = (state_q == GNT_A) ? i_a_valid : i_b_valid;
    assign g_last    = (state_q == GNT_A) ? i_a_last : i_b_last;
    assign o_timeout = timeout_q;

    // State, fairness pointer, stall counter and timeout pulse registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: packet locking, tie-break and stall timeout
    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        cnt_d     = '0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_a_valid && i_b_valid) begin
`ifdef ARB_FIXED_PRIO_EN
                    state_d = GNT_A;
`else
                    state_d = last_b_q ? GNT_A : GNT_B;
`endif
                end else if (i_a_valid) begin
                    state_d = GNT_A;
                end else if (i_b_valid) begin
                    state_d = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (g_valid && i_ready) begin
                    // a transfer always clears the stall counter
                    if (g_last) begin
                        state_d  = IDLE;
                        last_b_d = (state_q == GNT_B);
                    end
                end else if (!g_valid) begin
                    if (cnt_q == TO_MAX) begin
                        state_d   = IDLE;
                        last_b_d  = (state_q == GNT_B);
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // UART backpressure: hold, never time out
                    cnt_d = cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: zero-latency pass-through of the granted port
    always_comb begin
        o_data    = '0;
        o_valid   = 1'b0;
        o_a_ready = 1'b0;
        o_b_ready = 1'b0;
        o_grant   = 2'b00;
        case (state_q)
            GNT_A: begin
                o_data    = i_a_data;
                o_valid   = i_a_valid;
                o_a_ready = i_ready;
                o_grant   = 2'b01;
            end
            GNT_B: begin
                o_data    = i_b_data;
                o_valid   = i_b_valid;
                o_b_ready = i_ready;
                o_grant   = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for the UART TX packet arbiter.
// Sources are byte queues; accepted bytes are logged with the grant.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic       a_last = 1'b0;
    logic       a_ready;
    logic [7:0] b_data = '0;
    logic       b_valid = 1'b0;
    logic       b_last = 1'b0;
    logic       b_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       ready = 1'b1;
    logic [1:0] grant;
    logic       tout;

    int total = 0;
    int bad = 0;

    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [9:0] xlog[$];
    logic [1:0] glog[$];
    logic       tlog[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_W(8),
        .TIMEOUT_CYC(16),
        .CNT_W(14)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_a_data(a_data),
        .i_a_valid(a_valid),
        .i_a_last(a_last),
        .o_a_ready(a_ready),
        .i_b_data(b_data),
        .i_b_valid(b_valid),
        .i_b_last(b_last),
        .o_b_ready(b_ready),
        .o_data(o_data),
        .o_valid(o_valid),
        .i_ready(ready),
        .o_grant(grant),
        .o_timeout(tout)
    );

    task automatic drive;
        a_valid = (qa.size() > 0);
        a_data  = a_valid ? qa[0][7:0] : 8'h00;
        a_last  = a_valid ? qa[0][8] : 1'b0;
        b_valid = (qb.size() > 0);
        b_data  = b_valid ? qb[0][7:0] : 8'h00;
        b_last  = b_valid ? qb[0][8] : 1'b0;
    endtask

    task automatic cyc;
        bit ha;
        bit hb;
        drive();
        @(negedge clk);
        glog.push_back(grant);
        tlog.push_back(tout);
        if (o_valid && ready) xlog.push_back({grant, o_data});
        ha = a_valid && a_ready;
        hb = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (ha) void'(qa.pop_front());
        if (hb) void'(qb.pop_front());
    endtask

    task automatic do_reset;
        qa.delete();
        qb.delete();
        xlog.delete();
        glog.delete();
        tlog.delete();
        ready = 1'b1;
        drive();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        qa.delete();
        qb.delete();
        qa.push_back({1'b0, 8'hAA});
        drive();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", o_valid);
        end
        total++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b%b want=00", a_ready, b_ready);
        end
        total++;
        if (o_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data got=%h want=00", o_data);
        end
        total++;
        if (grant !== 2'b00) begin
            bad++;
            $display("FAIL reset_grant got=%b want=00", grant);
        end
        total++;
        if (tout !== 1'b0) begin
            bad++;
            $display("FAIL reset_timeout got=%b want=0", tout);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_packet;
        logic [9:0] ex[3];
        logic [1:0] eg[6];
        ex = '{{2'b01, 8'h1B}, {2'b01, 8'h5B}, {2'b01, 8'h41}};
        eg = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        do_reset();
        qa.push_back({1'b0, 8'h1B});
        qa.push_back({1'b0, 8'h5B});
        qa.push_back({1'b1, 8'h41});
        repeat (6) cyc();
        total++;
        if (xlog.size() !== 3) begin
            bad++;
            $display("FAIL pkt_count got=%0d want=3", xlog.size());
        end
        for (int i = 0; i < 3 && i < xlog.size(); i++) begin
            total++;
            if (xlog[i] !== ex[i]) begin
                bad++;
                $display("FAIL pkt_byte%0d got=%h want=%h", i, xlog[i], ex[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (glog[i] !== eg[i]) begin
                bad++;
                $display("FAIL pkt_grant%0d got=%b want=%b", i, glog[i], eg[i]);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] eg[7];
        logic [9:0] ex[8];
        eg = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        ex = '{{2'b01, 8'h11}, {2'b01, 8'h12}, {2'b10, 8'h21}, {2'b10, 8'h22},
               {2'b01, 8'h11}, {2'b01, 8'h12}, {2'b10, 8'h21}, {2'b10, 8'h22}};
        do_reset();
        for (int r = 0; r < 2; r++) begin
            qa.push_back({1'b0, 8'h11});
            qa.push_back({1'b1, 8'h12});
            qb.push_back({1'b0, 8'h21});
            qb.push_back({1'b1, 8'h22});
            repeat (8) cyc();
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (glog[i] !== eg[i]) begin
                bad++;
                $display("FAIL rr_grant%0d got=%b want=%b", i, glog[i], eg[i]);
            end
        end
        total++;
        if (xlog.size() !== 8) begin
            bad++;
            $display("FAIL rr_count got=%0d want=8", xlog.size());
        end
        for (int i = 0; i < 8 && i < xlog.size(); i++) begin
            total++;
            if (xlog[i] !== ex[i]) begin
                bad++;
                $display("FAIL rr_byte%0d got=%h want=%h", i, xlog[i], ex[i]);
            end
        end
    endtask

    task automatic test_requeue;
        logic [9:0] ex[6];
`ifdef ARB_FIXED_PRIO_EN
        ex = '{{2'b01, 8'h11}, {2'b01, 8'h12}, {2'b01, 8'h11},
               {2'b01, 8'h12}, {2'b10, 8'h21}, {2'b10, 8'h22}};
`else
        ex = '{{2'b01, 8'h11}, {2'b01, 8'h12}, {2'b10, 8'h21},
               {2'b10, 8'h22}, {2'b01, 8'h11}, {2'b01, 8'h12}};
`endif
        do_reset();
        qa.push_back({1'b0, 8'h11});
        qa.push_back({1'b1, 8'h12});
        qa.push_back({1'b0, 8'h11});
        qa.push_back({1'b1, 8'h12});
        qb.push_back({1'b0, 8'h21});
        qb.push_back({1'b1, 8'h22});
        repeat (12) cyc();
        total++;
        if (xlog.size() !== 6) begin
            bad++;
            $display("FAIL rq_count got=%0d want=6", xlog.size());
        end
        for (int i = 0; i < 6 && i < xlog.size(); i++) begin
            total++;
            if (xlog[i] !== ex[i]) begin
                bad++;
                $display("FAIL rq_byte%0d got=%h want=%h", i, xlog[i], ex[i]);
            end
        end
    endtask

    task automatic test_timeout;
        int pulses;
        do_reset();
        qa.push_back({1'b0, 8'h1B});
        qb.push_back({1'b1, 8'h30});
        repeat (22) cyc();
        pulses = 0;
        foreach (tlog[i]) pulses += int'(tlog[i]);
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL to_pulses got=%0d want=1", pulses);
        end
        total++;
        if (tlog[18] !== 1'b1) begin
            bad++;
            $display("FAIL to_pulse_cyc got=%b want=1", tlog[18]);
        end
        total++;
        if (glog[17] !== 2'b01) begin
            bad++;
            $display("FAIL to_hold got=%b want=01", glog[17]);
        end
        total++;
        if (glog[18] !== 2'b00) begin
            bad++;
            $display("FAIL to_idle got=%b want=00", glog[18]);
        end
        total++;
        if (glog[19] !== 2'b10) begin
            bad++;
            $display("FAIL to_next got=%b want=10", glog[19]);
        end
        total++;
        if (xlog.size() !== 2 || xlog[0] !== {2'b01, 8'h1B}
            || xlog[1] !== {2'b10, 8'h30}) begin
            bad++;
            $display("FAIL to_bytes got=%0d want=2 (1B then 30)", xlog.size());
        end
    endtask

    task automatic test_backpressure;
        int errs;
        do_reset();
        ready = 1'b0;
        qa.push_back({1'b1, 8'h55});
        cyc();
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            drive();
            @(negedge clk);
            if (o_valid !== 1'b1 || o_data !== 8'h55 || tout !== 1'b0
                || grant !== 2'b01) errs++;
            @(posedge clk);
            #1;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL bp_hold got=%0d want=0 bad cycles", errs);
        end
        ready = 1'b1;
        repeat (3) cyc();
        total++;
        if (xlog.size() !== 1 || xlog[0] !== {2'b01, 8'h55}) begin
            bad++;
            $display("FAIL bp_xfer got=%0d want=1 byte 55", xlog.size());
        end
        total++;
        if (glog[2] !== 2'b00) begin
            bad++;
            $display("FAIL bp_idle got=%b want=00", glog[2]);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] ex[3];
        ex = '{{2'b01, 8'h1B}, {2'b01, 8'h5B}, {2'b01, 8'h41}};
        do_reset();
        qa.push_back({1'b0, 8'h1B});
        qa.push_back({1'b0, 8'h5B});
        qa.push_back({1'b1, 8'h41});
        repeat (3) cyc();
        drive();
        rst = 1'b1;
        #1;
        total++;
        if (o_valid !== 1'b0 || grant !== 2'b00 || a_ready !== 1'b0
            || o_data !== 8'h00) begin
            bad++;
            $display("FAIL rm_outputs got=%b%b%b%h want=0000", o_valid,
                     grant, a_ready, o_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        glog.delete();
        repeat (4) cyc();
        total++;
        if (glog[0] !== 2'b00 || glog[1] !== 2'b01) begin
            bad++;
            $display("FAIL rm_regrant got=%b,%b want=00,01", glog[0], glog[1]);
        end
        total++;
        if (xlog.size() !== 3) begin
            bad++;
            $display("FAIL rm_count got=%0d want=3", xlog.size());
        end
        for (int i = 0; i < 3 && i < xlog.size(); i++) begin
            total++;
            if (xlog[i] !== ex[i]) begin
                bad++;
                $display("FAIL rm_byte%0d got=%h want=%h", i, xlog[i], ex[i]);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_packet();
        test_round_robin();
        test_requeue();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single PC-bound UART transmitter (AXI-stream byte input, 12 MHz domain) between two byte requesters: port A (keyboard key codes) and port B (terminal replies such as status or answerback strings).
- Grants whole packets, delimited by a last flag, so multi-byte escape sequences are never interleaved.
- Arbitration is round-robin between packets.
- A starvation timeout reclaims the grant from a requester that stalls mid-packet.

Parameters:
DATA_W, 8, byte width of all data paths.
TIMEOUT_CYC, 12000, cycles (1 ms at 12 MHz) a granted requester may hold valid low mid-packet before the grant is revoked.
CNT_W, 14, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
i_clk  in  1  system clock, 12 MHz.
i_rst  in  1  reset, asynchronous, active-high.
i_a_data  in  DATA_W  port A byte.
i_a_valid  in  1  port A byte valid.
i_a_last  in  1  port A byte ends the packet.
o_a_ready  out  1  port A byte accepted.
i_b_data  in  DATA_W  port B byte.
i_b_valid  in  1  port B byte valid.
i_b_last  in  1  port B byte ends the packet.
o_b_ready  out  1  port B byte accepted.
o_data  out  DATA_W  byte to UART s_axis_tdata.
o_valid  out  1  to UART s_axis_tvalid.
i_ready  in  1  from UART s_axis_tready.
o_grant  out  2  one-hot current owner: bit0 = A, bit1 = B; 00 when idle.
o_timeout  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; last_served=B, so A wins the first tie.
  - Timeout counter=0.
  - o_grant=00, o_timeout=0.
  - o_valid=0, o_a_ready=0, o_b_ready=0, o_data=0.
- Reset mid-packet drops the grant. No byte is lost or duplicated: only completed valid&ready handshakes count as transfers.
- FSM states: IDLE, GNT_A, GNT_B. State and last_served are registered.
- IDLE:
  - o_valid=0, both readys 0, o_data=0.
  - Only A valid -> GNT_A. Only B valid -> GNT_B.
  - Both valid -> grant the port not equal to last_served.
  - Neither valid -> stay in IDLE.
  - One bubble cycle always separates packets.
- GNT_x (combinational pass-through, zero latency):
  - o_data=i_x_data, o_valid=i_x_valid, o_x_ready=i_ready.
  - Other port's ready=0. o_grant one-hot for x.
- Transfer definition: i_x_valid & i_ready in GNT_x.
- Transfer with i_x_last=1:
  - Next state is IDLE; last_served<=x; counter<=0.
  - A single-byte packet (last on first byte) is legal.
- Transfer with i_x_last=0: stay in GNT_x; counter<=0.
- Timeout counter (GNT states only):
  - Increments on each cycle with i_x_valid=0.
  - Holds when i_x_valid=1 and i_ready=0; UART backpressure never causes a timeout.
  - Cleared on every transfer and on entering IDLE.
- Counter reaching TIMEOUT_CYC-1 while i_x_valid=0:
  - Next state is IDLE; last_served<=x.
  - o_timeout=1 for exactly one cycle, the cycle after the expiry edge.
  - The remainder of that packet arrives later as a new packet.
- AXI rule: the block never deasserts o_valid while i_ready=0 once it has asserted it, because the grant changes only on a transfer or while valid is low.
- Simultaneous events:
  - Transfer on the expiry cycle: the transfer wins and the counter clears.
  - New requests arriving while granted wait in their source; no internal buffering.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: IDLE tie-break is fixed, A always before B, so keyboard latency is minimal. last_served is still maintained but ignored.
- Undefined: round-robin as above.
- Packet locking and timeout are identical in both builds.

Test Plan:
- Reset, then A sends packet 0x1B,0x5B,0x41 (last on 0x41) with i_ready=1 -> o_data sequence 1B,5B,41 on consecutive cycles, o_grant=01, then IDLE one cycle with o_grant=00.
- A and B both valid from the same cycle, 2-byte packets A=11,12 and B=21,22 -> output 11,12,bubble,21,22; repeat both -> A first again, since last_served=B after the first round.
- Same stimulus with ARB_FIXED_PRIO_EN and A re-requesting immediately -> output 11,12,11,12; B is served only once A is idle.
- A sends 0x1B without last, then drops valid; TIMEOUT_CYC=16 -> o_timeout pulses once after 16 idle cycles, then B's pending byte 0x30 is granted next.
- GNT_A with i_a_valid=1 and i_ready held 0 for 50 cycles (TIMEOUT_CYC=16) -> no timeout, o_valid stays 1 with o_data stable, byte transfers when i_ready rises.
- Assert i_rst mid-packet (after 0x5B accepted) -> outputs immediately zero, o_grant=00; after release, A's 0x41 is granted as a new packet.
